// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request bus between fetch_ctrl (master) and the memory (slave).
// Handshake: the master raises imem_req with imem_addr and holds both stable until a cycle
// in which imem_ack is high; that cycle completes the transfer and imem_rdata is valid in it.
interface fetch_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues memory requests and presents one
// registered instruction to IF/ID. Optional counters stat_wait/stat_discard under `FETCH_STAT_EN.
module fetch_ctrl #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_req,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  fetch_ctrl_if.master      imem,
  output logic              ce,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic              stall_if,
  output logic [1:0]        dbg_state
`ifdef FETCH_STAT_EN
  ,
  output logic [31:0]       stat_wait,
  output logic [31:0]       stat_discard
`endif
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              ce_q, ce_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              req_hold_q, req_hold_d;

  logic req, ack_v, consume, take_branch;

  assign req = (state_q != S_RESET) &&
               (req_hold_q || (state_q == S_DRAIN) || !(inst_valid_q && stall_req));
  assign ack_v       = req && imem.imem_ack;
  assign consume     = inst_valid_q && !stall_req;
  assign take_branch = branch_flag && !stall_req;

  always_comb begin
    state_d      = state_q;
    ce_d         = ce_q;
    fetch_addr_d = fetch_addr_q;
    target_d     = target_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q && !consume;
    req_hold_d   = ack_v ? 1'b0 : (req ? 1'b1 : req_hold_q);

    case (state_q)
      S_RESET: begin
        state_d = S_FETCH;
        ce_d    = 1'b1;
      end
      S_FETCH: begin
        if (flush) begin
          inst_valid_d = 1'b0;
          if (req && !ack_v) begin
            state_d  = S_DRAIN;
            target_d = new_pc;
          end else begin
            fetch_addr_d = new_pc;
          end
        end else if (take_branch) begin
          // A word arriving while the output is empty is the delay slot and is kept.
          if (ack_v && !inst_valid_q) begin
            inst_d       = imem.imem_rdata;
            pc_d         = fetch_addr_q;
            inst_valid_d = 1'b1;
          end
          if (req && !ack_v) begin
            state_d  = S_DRAIN;
            target_d = branch_target;
          end else begin
            fetch_addr_d = branch_target;
          end
        end else if (ack_v) begin
          inst_d       = imem.imem_rdata;
          pc_d         = fetch_addr_q;
          inst_valid_d = 1'b1;
          fetch_addr_d = fetch_addr_q + ADDR_W'(4);
        end
      end
      S_DRAIN: begin
        if (flush) begin
          inst_valid_d = 1'b0;
          target_d     = new_pc;
        end else if (take_branch) begin
          target_d = branch_target;
        end
        // The old request completes here; its data is dropped and fetch restarts at the target.
        if (ack_v) begin
          state_d      = S_FETCH;
          fetch_addr_d = target_d;
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RESET;
      ce_q         <= 1'b0;
      fetch_addr_q <= RESET_PC;
      target_q     <= RESET_PC;
      pc_q         <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      req_hold_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ce_q         <= ce_d;
      fetch_addr_q <= fetch_addr_d;
      target_q     <= target_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      req_hold_q   <= req_hold_d;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = fetch_addr_q;
  assign ce             = ce_q;
  assign pc             = pc_q;
  assign inst           = inst_q;
  assign inst_valid     = inst_valid_q;
  assign stall_if       = req && !imem.imem_ack;
  assign dbg_state      = state_q;

`ifdef FETCH_STAT_EN
  logic [31:0] stat_wait_q, stat_wait_d;
  logic [31:0] stat_discard_q, stat_discard_d;
  logic        discard_ack;

  assign discard_ack = ack_v && ((state_q == S_DRAIN) ||
                       ((state_q == S_FETCH) && (flush || (take_branch && inst_valid_q))));

  always_comb begin
    stat_wait_d    = stat_wait_q;
    stat_discard_d = stat_discard_q;
    if (stall_if && !(&stat_wait_q))       stat_wait_d    = stat_wait_q + 32'd1;
    if (discard_ack && !(&stat_discard_q)) stat_discard_d = stat_discard_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_wait_q    <= '0;
      stat_discard_q <= '0;
    end else begin
      stat_wait_q    <= stat_wait_d;
      stat_discard_q <= stat_discard_d;
    end
  end

  assign stat_wait    = stat_wait_q;
  assign stat_discard = stat_discard_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a memory model acks from a grant budget, and two
// scoreboards check request addresses and consumed {pc, inst} pairs.
module tb_fetch_ctrl;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst, stall_req, flush, branch_flag;
  logic [AW-1:0] new_pc, branch_target;
  logic          ce, inst_valid, stall_if;
  logic [AW-1:0] pc;
  logic [31:0]   inst;
  logic [1:0]    dbg_state;
`ifdef FETCH_STAT_EN
  logic [31:0]   stat_wait, stat_discard;
`endif

  fetch_ctrl_if #(.ADDR_W(AW)) bus ();

  fetch_ctrl #(.ADDR_W(AW), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_req     (stall_req),
    .flush         (flush),
    .new_pc        (new_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .imem          (bus),
    .ce            (ce),
    .pc            (pc),
    .inst          (inst),
    .inst_valid    (inst_valid),
    .stall_if      (stall_if),
    .dbg_state     (dbg_state)
`ifdef FETCH_STAT_EN
    ,
    .stat_wait     (stat_wait),
    .stat_discard  (stat_discard)
`endif
  );

  // clock
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [63:0] out_q[$];
  logic [31:0] addr_q[$];
  int budget = 0;
  int mem_wait = 0;
  int wait_cnt = 0;
  int cnt = 0;
  bit force_ack = 1'b0;
  logic [31:0] start_addr;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic expect_fetch(input logic [31:0] a, input bit delivered);
    addr_q.push_back(a);
    if (delivered) out_q.push_back({a, word(a)});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ce"}, ce, 0);
    chk({tag, "_req"}, bus.imem_req, 0);
    chk({tag, "_addr"}, bus.imem_addr, 0);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_inst"}, inst, 0);
    chk({tag, "_valid"}, inst_valid, 0);
    chk({tag, "_stall_if"}, stall_if, 0);
    chk({tag, "_state"}, dbg_state, 0);
`ifdef FETCH_STAT_EN
    chk({tag, "_stat_wait"}, stat_wait, 0);
    chk({tag, "_stat_discard"}, stat_discard, 0);
`endif
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while ((out_q.size() != 0 || addr_q.size() != 0) && n < max) begin
      @(negedge clk);
      #3;
      n++;
    end
    checks++;
    if (out_q.size() == 0 && addr_q.size() == 0) passes++;
    else $display("FAIL drain: %0d outputs and %0d requests still pending after %0d cycles",
                  out_q.size(), addr_q.size(), n);
  endtask

  // memory model: acks only while budget > 0, after mem_wait wait cycles
  always @(negedge clk) begin
    #1;
    if (force_ack) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hBAD0_BAD0;
    end else if (rst || !bus.imem_req || budget == 0) begin
      bus.imem_ack = 1'b0;
      cnt = 0;
    end else begin
      if (cnt == 0) start_addr = bus.imem_addr;
      if (cnt >= mem_wait) begin
        if (cnt > 0) chk("addr_stable", bus.imem_addr, start_addr);
        if (addr_q.size() == 0) begin
          checks++;
          $display("FAIL req_unexpected: addr %0h acked with nothing expected", bus.imem_addr);
        end else begin
          chk("req_addr", bus.imem_addr, addr_q.pop_front());
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word(bus.imem_addr);
        budget--;
        cnt = 0;
      end else begin
        bus.imem_ack = 1'b0;
        cnt++;
      end
    end
  end

  // output monitor: compares every consumed instruction against the expected queue
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (stall_if && budget > 0) wait_cnt++;
      if (inst_valid && !stall_req) begin
        if (out_q.size() == 0) begin
          checks++;
          $display("FAIL out_unexpected: pc %0h consumed with nothing expected", pc);
        end else begin
          chk("out_pc_inst", {pc, inst}, out_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1; stall_req = 1'b0; flush = 1'b0; branch_flag = 1'b0;
    new_pc = '0; branch_target = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #3;
    chk_reset("reset");

    // sequential fetch, zero-wait memory
    rst = 1'b0; budget = 3;
    expect_fetch(32'h0, 1); expect_fetch(32'h4, 1); expect_fetch(32'h8, 1);
    @(negedge clk); #3;
    chk("ce_after_reset", ce, 1);
    chk("first_req", bus.imem_req, 1);
    chk("first_addr", bus.imem_addr, 32'h0);
    chk("state_fetch", dbg_state, 1);
    wait_drain(40);
    chk("pending_addr_c", bus.imem_addr, 32'hC);
    chk("stall_if_waiting", stall_if, 1);

    // two wait cycles per fetch
    @(negedge clk);
    mem_wait = 2; budget = 2; wait_cnt = 0;
    expect_fetch(32'hC, 1); expect_fetch(32'h10, 1);
    wait_drain(40);
    chk("wait_cycles", wait_cnt, 4);

    // downstream stall holds the output and suppresses requests
    @(negedge clk);
    mem_wait = 0; budget = 1;
    expect_fetch(32'h14, 1);
    @(negedge clk);
    stall_req = 1'b1; budget = 1;
    expect_fetch(32'h18, 1);
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("stall_valid", inst_valid, 1);
      chk("stall_pc", pc, 32'h14);
      chk("stall_no_req", bus.imem_req, 0);
      chk("stall_addr", bus.imem_addr, 32'h18);
      @(negedge clk);
    end
    stall_req = 1'b0;

    // branch while the request at 0x1C is outstanding and delay slot 0x18 is presented
    @(negedge clk);
    branch_flag = 1'b1; branch_target = 32'h100;
    expect_fetch(32'h1C, 0); expect_fetch(32'h100, 1);
    @(negedge clk);
    branch_flag = 1'b0;
    #3;
    chk("branch_drain_state", dbg_state, 2);
    chk("branch_drain_req", bus.imem_req, 1);
    chk("branch_drain_addr", bus.imem_addr, 32'h1C);
    chk("branch_drain_valid", inst_valid, 0);
    @(negedge clk);
    budget = 2;
    wait_drain(40);

    // flush + branch together with a same-cycle ack: flush wins, ack data dropped
    @(negedge clk);
    flush = 1'b1; new_pc = 32'h20; branch_flag = 1'b1; branch_target = 32'h200; budget = 2;
    expect_fetch(32'h104, 0); expect_fetch(32'h20, 1);
    @(negedge clk);
    flush = 1'b0; branch_flag = 1'b0;
    #3;
    chk("flush_valid", inst_valid, 0);
    chk("flush_addr", bus.imem_addr, 32'h20);
    chk("flush_state", dbg_state, 1);
    wait_drain(40);

    // flush into DRAIN, second flush overwrites the target; target wraps past the top
    @(negedge clk);
    flush = 1'b1; new_pc = 32'h40;
    @(negedge clk);
    new_pc = 32'hFFFF_FFFC;
    #3;
    chk("flush_drain_state", dbg_state, 2);
    chk("flush_drain_addr", bus.imem_addr, 32'h24);
    @(negedge clk);
    flush = 1'b0; budget = 3;
    expect_fetch(32'h24, 0); expect_fetch(32'hFFFF_FFFC, 1); expect_fetch(32'h0, 1);
    wait_drain(40);
    chk("wrap_next_addr", bus.imem_addr, 32'h4);
`ifdef FETCH_STAT_EN
    chk("stat_discard", stat_discard, 3);
`endif

    // reset with a request outstanding and a late ack in the same cycle
    @(negedge clk);
    rst = 1'b1; force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    #3;
    chk_reset("mid_reset");
    @(negedge clk);
    rst = 1'b0; budget = 1;
    expect_fetch(32'h0, 1);
    wait_drain(40);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
